// File: rtl/hilo_div_ctrl.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, sole writer of HI/LO for divide results.
// Latency: WIDTH+1 cycles from accepted start to the one-cycle HI/LO write (1 cycle on divide-by-zero).
// Backpressure: holds the pipeline via stallreq while accepting/iterating; start is ignored while busy.
module hilo_div_ctrl #(
   parameter int WIDTH     = 32,
   parameter bit DBZ_WRITE = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             signed_op,
   input  logic             annul,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             stallreq,
   output logic             done,
   output logic             hi_we,
   output logic             lo_we,
   output logic [WIDTH-1:0] hi_wdata,
   output logic [WIDTH-1:0] lo_wdata
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             sign_q;
   logic             sign_r;
   logic             dbz;

   logic             accept;
   logic             last;
   logic             dvd_neg;
   logic             dvs_neg;
   logic             dvs_zero;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH:0]   shl;
   logic [WIDTH:0]   trial;
   logic             ge;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;

   // Operand conditioning and one restoring-division step.
   // The trial subtract is WIDTH+1 bits: the true difference lies in [-dvs, dvs-1],
   // which always fits, so its MSB is a reliable sign even for a 2^(WIDTH-1) magnitude.
   always_comb begin
      accept   = (state == IDLE) && start && !annul;
      last     = (cnt == CW'(WIDTH - 1));
      dvd_neg  = signed_op & dividend[WIDTH-1];
      dvs_neg  = signed_op & divisor[WIDTH-1];
      dvs_zero = (divisor == '0);
      dvd_mag  = dvd_neg ? (~dividend + 1'b1) : dividend;
      dvs_mag  = dvs_neg ? (~divisor + 1'b1) : divisor;
      shl      = {rem, quo[WIDTH-1]};
      trial    = shl - {1'b0, dvs};
      ge       = ~trial[WIDTH];
      rem_nxt  = ge ? trial[WIDTH-1:0] : shl[WIDTH-1:0];
      quo_nxt  = {quo[WIDTH-2:0], ge};
      q_fin    = sign_q ? (~quo_nxt + 1'b1) : quo_nxt;
      r_fin    = sign_r ? (~rem_nxt + 1'b1) : rem_nxt;
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state and control outputs; annul dominates, and gates the DONE-cycle write.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      stallreq  = 1'b0;
      done      = 1'b0;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = dvs_zero ? DONE : CALC;
         end
         CALC: begin
            if (annul)     state_nxt = IDLE;
            else if (last) state_nxt = DONE;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      busy     = resetn && (state != IDLE);
      stallreq = resetn && (accept || (state == CALC));
      done     = resetn && (state == DONE) && !annul;
      hi_we    = done && (!dbz || DBZ_WRITE);
      lo_we    = hi_we;
   end

   // Datapath: latch operands on accept, iterate in CALC, register signed results on the final step.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         dbz      <= 1'b0;
         hi_wdata <= '0;
         lo_wdata <= '0;
      end else if (accept) begin
         cnt    <= '0;
         rem    <= '0;
         quo    <= dvd_mag;
         dvs    <= dvs_mag;
         sign_q <= dvd_neg ^ dvs_neg;
         sign_r <= dvd_neg;
         dbz    <= dvs_zero;
         if (dvs_zero) begin
            lo_wdata <= '1;
            hi_wdata <= dividend;
         end
      end else if ((state == CALC) && !annul) begin
         rem <= rem_nxt;
         quo <= quo_nxt;
         cnt <= cnt + 1'b1;
         if (last) begin
            lo_wdata <= q_fin;
            hi_wdata <= r_fin;
         end
      end
   end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed plus randomized checks of the divide sequencer against an arithmetic reference.
// Latency: checks WIDTH+1 cycle completion and 1-cycle divide-by-zero.
// Backpressure: checks stallreq/busy profile, annul aborts and ignored starts while busy.
module tb_hilo_div_ctrl;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        signed_op;
   logic        annul;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy, stallreq, done, hi_we, lo_we;
   logic [31:0] hi_wdata, lo_wdata;
   logic        busy0, stallreq0, done0, hi_we0, lo_we0;
   logic [31:0] hi_wdata0, lo_wdata0;

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int exp_wr = 0;

   hilo_div_ctrl #(.WIDTH(32), .DBZ_WRITE(1'b1)) dut (
      .clk(clk), .resetn(resetn), .start(start), .signed_op(signed_op), .annul(annul),
      .dividend(dividend), .divisor(divisor), .busy(busy), .stallreq(stallreq),
      .done(done), .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
   );

   hilo_div_ctrl #(.WIDTH(32), .DBZ_WRITE(1'b0)) dut0 (
      .clk(clk), .resetn(resetn), .start(start), .signed_op(signed_op), .annul(annul),
      .dividend(dividend), .divisor(divisor), .busy(busy0), .stallreq(stallreq0),
      .done(done0), .hi_we(hi_we0), .lo_we(lo_we0), .hi_wdata(hi_wdata0), .lo_wdata(lo_wdata0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count HI/LO writes observed mid-cycle.
   always @(negedge clk) if (hi_we === 1'b1) wr_cnt <= wr_cnt + 1;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic, truncating signed division, remainder follows dividend.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] q, output logic [31:0] r);
      longint sa, sb, lq, lr;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         lq = sa / sb;
         lr = sa % sb;
         q  = lq[31:0];
         r  = lr[31:0];
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   // Issue a divide from an IDLE cycle (called at posedge+1), check profile and result.
   // inject: pulse a conflicting start with other operands mid-CALC.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input bit inject);
      logic [31:0] eq, er;
      int cyc;
      int exp_lat;
      bit found;
      bit prof_ok;
      ref_div(a, b, s, eq, er);
      exp_lat = (b == 32'd0) ? 1 : 33;
      dividend = a; divisor = b; signed_op = s; start = 1'b1;
      #1;
      chk("stall_c0", stallreq, 1'b1);
      cyc = 0; found = 0; prof_ok = 1;
      while (cyc < 60 && !found) begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         if (done === 1'b1) found = 1;
         else if (stallreq !== 1'b1 || busy !== 1'b1) prof_ok = 0;
         if (inject && cyc == 5) begin
            start = 1'b1; dividend = 32'd99; divisor = 32'd3; signed_op = ~s;
         end
      end
      chk("found_done", found, 1'b1);
      chk("latency", cyc, exp_lat);
      chk("calc_profile", prof_ok, 1'b1);
      chk("stall_done", stallreq, 1'b0);
      chk("hi_we", hi_we, 1'b1);
      chk("lo_we", lo_we, 1'b1);
      chk("lo_wdata", lo_wdata, eq);
      chk("hi_wdata", hi_wdata, er);
      if (b == 32'd0) begin
         chk("dbz0_done", done0, 1'b1);
         chk("dbz0_we", {30'd0, hi_we0, lo_we0}, 32'd0);
      end else begin
         chk("nodbz0_lo", lo_wdata0, eq);
      end
      exp_wr++;
      @(posedge clk); #1;
      chk("busy_after", busy, 1'b0);
      chk("done_after", done, 1'b0);
   endtask

   logic [31:0] da [8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF,
                            32'h1234, 32'h8000_0000, 32'h7FFF_FFFF};
   logic [31:0] db [8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1,
                            32'd0, 32'h8000_0000, 32'd1};
   logic        ds [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      int          w0;
      resetn = 1'b0; start = 1'b0; signed_op = 1'b0; annul = 1'b0;
      dividend = '0; divisor = '0;
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_stall", stallreq, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_hi", hi_wdata, 32'd0);
      chk("rst_lo", lo_wdata, 32'd0);
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;

      // Directed cases.
      for (int i = 0; i < 8; i++) do_div(da[i], db[i], ds[i], 0);

      // Randomized cases.
      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if ($urandom_range(0, 1) == 1) rb = -rb;
         rs = 1'($urandom_range(0, 1));
         do_div(ra, rb, rs, 0);
      end

      // Annul in CALC at cycle 10, then a fresh start in cycle 11.
      w0 = wr_cnt;
      dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0; start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      annul = 1'b1;
      @(posedge clk); #1;
      annul = 1'b0;
      chk("annul_busy", busy, 1'b0);
      chk("annul_stall", stallreq, 1'b0);
      chk("annul_nowr", wr_cnt, w0);
      do_div(32'd12345, 32'd11, 1'b0, 0);

      // Annul coinciding with the DONE cycle.
      dividend = 32'd50; divisor = 32'd5; signed_op = 1'b0; start = 1'b1;
      begin : wait_done
         bit seen;
         seen = 0;
         for (int c = 0; c < 60 && !seen; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) seen = 1;
         end
         chk("ad_seen", seen, 1'b1);
      end
      w0 = wr_cnt;
      annul = 1'b1;
      #1;
      chk("ad_done", done, 1'b0);
      chk("ad_we", {30'd0, hi_we, lo_we}, 32'd0);
      @(posedge clk); #1;
      annul = 1'b0;
      chk("ad_nowr", wr_cnt, w0);
      chk("ad_idle", busy, 1'b0);

      // Asynchronous reset mid-CALC.
      w0 = wr_cnt;
      dividend = 32'h12345; divisor = 32'd17; signed_op = 1'b0; start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("pre_rst_busy", busy, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_stall", stallreq, 1'b0);
      chk("arst_we", {30'd0, hi_we, lo_we}, 32'd0);
      chk("arst_hi", hi_wdata, 32'd0);
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;
      chk("arst_nowr", wr_cnt, w0);
      do_div(32'd1000, 32'd7, 1'b0, 1);
      do_div(32'hFFFF_FF00, 32'd9, 1'b1, 1);

      @(negedge clk);
      chk("write_count", wr_cnt, exp_wr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
